// File: rtl/timer_pkg.sv
// Shared definitions for the timer register block and its access sequencer:
// register map, TCR field layout and the sequencer state encoding.
package timer_pkg;

   typedef enum logic [11:0] {
      TCR_OFF   = 12'h000,
      TDR0_OFF  = 12'h004,
      TDR1_OFF  = 12'h008,
      TCMP0_OFF = 12'h00C,
      TCMP1_OFF = 12'h010,
      TIER_OFF  = 12'h014,
      TISR_OFF  = 12'h018,
      THCSR_OFF = 12'h01C
   } reg_off_e;

   localparam int TCR_EN_BIT     = 0;
   localparam int TCR_DIV_EN_BIT = 1;
   localparam int TCR_DIV_LSB    = 8;
   localparam int TCR_DIV_MSB    = 11;

   localparam logic [3:0] TCR_MAX_DIV = 4'h8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   function automatic logic [1:0] idx2oh(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/timer_reg_arbiter_if.sv
// Requester-side bus of the register access sequencer: two packed requester
// lanes ({lane1,lane0}) plus the per-lane completion response.
interface timer_reg_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [1:0]          req;
   logic [1:0]          we;
   logic [2*ADDR_W-1:0] addr;
   logic [2*DATA_W-1:0] wdata;
   logic [7:0]          wstrb;
   logic [1:0]          done;
   logic [1:0]          err;
   logic [DATA_W-1:0]   rsp_rdata;

   modport master (
      output req, we, addr, wdata, wstrb,
      input  done, err, rsp_rdata
   );

   modport slave (
      input  req, we, addr, wdata, wstrb,
      output done, err, rsp_rdata
   );
endinterface

// File: rtl/timer_rr_arb.sv
// Two-way round-robin grant. The pointer remembers the last winner; on a tie
// the other requester wins. Reset leaves requester 0 favoured.
module timer_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_idx_i,
   output logic       gnt_idx_o,
   output logic       gnt_vld_o
);

   logic last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (upd_i) begin
         last_q <= upd_idx_i;
      end
   end

   always_comb begin
      gnt_vld_o = |req_i;
      if (req_i == 2'b11) begin
         gnt_idx_o = ~last_q;
      end else begin
         gnt_idx_o = req_i[1];
      end
   end

endmodule

// File: rtl/timer_reg_arbiter.sv
// Arbitrates the APB bridge (lane 0) and debug sequencer (lane 1) onto the
// timer register port, rejecting illegal accesses before they reach it.
//
// state  | meaning
// IDLE   | sample requests, latch winner's command and legality
// ACCESS | one-cycle strobe (or pslverr for an illegal command)
// WAIT   | wait for pready, bounded by TIMEOUT cycles
// RESP   | one-cycle done/err/rdata to the winner, advance rr pointer
module timer_reg_arbiter
   import timer_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 16,
   parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(THCSR_OFF),
   parameter logic [3:0]        MAX_DIV  = TCR_MAX_DIV
) (
   input  logic              clk,
   input  logic              rst,
   timer_reg_arbiter_if.slave rq,
   input  logic [DATA_W-1:0] tcr_in,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic [3:0]        reg_wstrb,
   output logic              reg_pslverr,
   input  logic              reg_pready,
   input  logic [DATA_W-1:0] reg_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_e            state_q;
   logic              win_q;
   logic              we_q;
   logic              illegal_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        wstrb_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              wr_en_q;
   logic              rd_en_q;
   logic              pslverr_q;
   logic [1:0]        done_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rdata_q;

   logic              gnt_idx;
   logic              gnt_vld;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_wstrb;
   logic [3:0]        div_new;
   logic              addr_bad;
   logic              div_bad;
   logic              illegal;
   logic              unused_tcr;

   timer_rr_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (rq.req),
      .upd_i     (state_q == ST_RESP),
      .upd_idx_i (win_q),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   always_comb begin
      sel_we    = rq.we[gnt_idx];
      sel_addr  = gnt_idx ? rq.addr[2*ADDR_W-1:ADDR_W]  : rq.addr[ADDR_W-1:0];
      sel_wdata = gnt_idx ? rq.wdata[2*DATA_W-1:DATA_W] : rq.wdata[DATA_W-1:0];
      sel_wstrb = gnt_idx ? rq.wstrb[7:4] : rq.wstrb[3:0];
      div_new   = sel_wdata[TCR_DIV_MSB:TCR_DIV_LSB];
      addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
      // Divider byte must stay in range and may not change while the timer runs.
      div_bad   = sel_we && (sel_addr == ADDR_W'(TCR_OFF)) && sel_wstrb[1] &&
                  ((div_new > MAX_DIV) ||
                   (tcr_in[TCR_EN_BIT] && (div_new != tcr_in[TCR_DIV_MSB:TCR_DIV_LSB])));
      illegal   = addr_bad || div_bad;
   end

   assign unused_tcr = ^{tcr_in[DATA_W-1:TCR_DIV_MSB+1], tcr_in[TCR_DIV_LSB-1:TCR_DIV_EN_BIT]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         win_q     <= 1'b0;
         we_q      <= 1'b0;
         illegal_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         pslverr_q <= 1'b0;
         done_q    <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         pslverr_q <= 1'b0;
         done_q    <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_vld) begin
                  win_q     <= gnt_idx;
                  we_q      <= sel_we;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  wstrb_q   <= sel_wstrb;
                  illegal_q <= illegal;
                  pslverr_q <= illegal;
                  wr_en_q   <= ~illegal & sel_we;
                  rd_en_q   <= ~illegal & ~sel_we;
                  state_q   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               cnt_q <= '0;
               if (illegal_q) begin
                  done_q  <= idx2oh(win_q);
                  err_q   <= idx2oh(win_q);
                  state_q <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (reg_pready) begin
                  done_q  <= idx2oh(win_q);
                  rdata_q <= we_q ? '0 : reg_rdata;
                  cnt_q   <= '0;
                  state_q <= ST_RESP;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  done_q  <= idx2oh(win_q);
                  err_q   <= idx2oh(win_q);
                  cnt_q   <= '0;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign reg_wr_en    = wr_en_q;
   assign reg_rd_en    = rd_en_q;
   assign reg_pslverr  = pslverr_q;
   assign reg_addr     = addr_q;
   assign reg_wdata    = wdata_q;
   assign reg_wstrb    = wstrb_q;
   assign rq.done      = done_q;
   assign rq.err       = err_q;
   assign rq.rsp_rdata = rdata_q;

endmodule
